// File: rtl/btn_press_queue.sv
// btn_press_queue
//   Turns rising edges on debounced button levels into button-index events,
//   queues them in a small FIFO and hands them to the consumer over a
//   valid/ready handshake. Simultaneous presses are serialised lowest index
//   first. A press that cannot be recorded because the same button is still
//   waiting to be queued sets a sticky overflow flag.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset, highest priority
//   btn_lvl   debounced button levels, synchronous to clk
//   ev_valid  head-of-queue event is valid
//   ev_idx    button index of the head event (0 while the queue is empty)
//   ev_ready  consumer takes the head event this cycle
//   ev_count  number of queued events, 0..DEPTH
//   overflow  sticky: at least one press was lost
//   clr_ovf   clears overflow (a simultaneous lost press wins)
module btn_press_queue #(
    parameter int NUM_BTN = 4,
    parameter int IDX_W   = 2,
    parameter int DEPTH   = 4,
    parameter int PTR_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_lvl,
    output logic               ev_valid,
    output logic [IDX_W-1:0]   ev_idx,
    input  logic               ev_ready,
    output logic [PTR_W:0]     ev_count,
    output logic               overflow,
    input  logic               clr_ovf
);

    logic [NUM_BTN-1:0] prev_lvl_q;
    logic [NUM_BTN-1:0] pend_q, pend_d;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] grant_mask;
    logic [IDX_W-1:0]   grant_idx;

    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [PTR_W:0]     count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [IDX_W-1:0]   mem_q [DEPTH];

    logic full, empty, push, pop, lost;

    assign rise = btn_lvl & ~prev_lvl_q;

    // x & -x isolates the lowest set bit.
    assign grant = pend_q & (~pend_q + NUM_BTN'(1));

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && ev_ready;

    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign push       = (pend_q != '0) && (!full || pop);
    assign grant_mask = push ? grant : '0;

    // A press on a bit that is still pending (and not leaving this cycle)
    // merges with the older one and is therefore lost.
    assign lost = |(rise & pend_q & ~grant_mask);

    assign pend_d     = (pend_q & ~grant_mask) | rise;
    assign overflow_d = lost ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
    assign count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // All ones so a button held through reset is not seen as a press.
            prev_lvl_q <= '1;
            pend_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_lvl_q <= btn_lvl;
            pend_q     <= pend_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wptr_q] <= grant_idx;
        end
    end

    assign ev_valid = !empty;
    assign ev_idx   = empty ? '0 : mem_q[rptr_q];
    assign ev_count = count_q;
    assign overflow = overflow_q;

endmodule

// File: doc/btn_press_queue.md
Name: btn_press_queue

Overview:
- Consumes the per-button debounced level signals and converts each rising edge (a press) into an event carrying the button index.
- Events are queued in a small FIFO and presented to the game-control FSM over a valid/ready handshake.
- Simultaneous presses are serialised, and no press is lost unless the queue backs up.
- Lost presses are flagged on a sticky overflow flag.

Parameters:
- NUM_BTN, 4, number of debounced button inputs.
- IDX_W, 2, width of the button index; must satisfy 2**IDX_W >= NUM_BTN.
- DEPTH, 4, FIFO depth in entries; must be a power of two.
- PTR_W, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_lvl  input  NUM_BTN  debounced button levels, already synchronous to clk.
- ev_valid  output  1  head-of-queue event is valid.
- ev_idx  output  IDX_W  button index of the head event.
- ev_ready  input  1  consumer accepts the head event this cycle.
- ev_count  output  PTR_W+1  number of queued events, 0..DEPTH.
- overflow  output  1  sticky flag: at least one press was lost.
- clr_ovf  input  1  clears overflow.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst and has priority over everything.
- Reset state:
  - prev_lvl = all ones, so a button held through reset produces no event.
  - pend = 0.
  - FIFO read and write pointers = 0, ev_count = 0.
  - ev_valid = 0, ev_idx = 0, overflow = 0.
  - FIFO storage contents are not reset.
- Edge detect:
  - prev_lvl <= btn_lvl every cycle.
  - rise = btn_lvl & ~prev_lvl.
- Pending mask (pend, NUM_BTN bits) holds detected presses not yet enqueued.
  - grant = lowest-index set bit of pend (one-hot), or 0 if pend == 0.
  - push = (pend != 0) && (!full || pop).
  - pend <= (pend & ~(push ? grant : 0)) | rise.
- Lost press:
  - A press is lost when rise[i] == 1 while pend[i] == 1 and that bit is not granted in the same cycle.
  - A lost press sets overflow.
- Overflow flag:
  - overflow <= 1 on any lost press; else 0 if clr_ovf; else hold.
  - If a lost press and clr_ovf occur in the same cycle, set wins.
- FIFO:
  - pop = ev_valid && ev_ready.
  - On push, write encoded index of grant at wptr; wptr <= wptr + 1.
  - On pop, rptr <= rptr + 1.
  - Both pointers wrap modulo DEPTH.
  - ev_count <= ev_count + push - pop.
  - full = (ev_count == DEPTH). empty = (ev_count == 0). ev_valid = !empty.
  - ev_idx = mem[rptr], combinational from registered pointers.
- Boundary rules:
  - Push and pop in the same cycle while full: allowed; count stays DEPTH.
  - Push and pop in the same cycle while count is 1: allowed; count stays 1 and the new entry becomes head.
  - Push into an empty FIFO: no bypass; ev_valid rises the cycle after the push edge.
  - ev_ready while empty: ignored; pointers and count unchanged.
  - When full with no pop: grant is withheld, pend bits hold, and further presses on those same bits are lost.
- Latency:
  - btn_lvl first sampled high at edge N sets pend at edge N.
  - The push occurs at edge N+1.
  - ev_valid = 1 after edge N+1, if the FIFO was not full.
- Event stability: ev_valid and ev_idx stay stable while ev_valid && !ev_ready. Head entries are never overwritten.
- Holding a button produces exactly one event. Release produces no event. Re-press after release produces a new event.
- rst asserted mid-operation: all queued and pending events are discarded on that edge, and overflow is cleared.

Test Plan:
- Reset with btn_lvl = 4'b0010 held, then release rst and keep the level held for 20 cycles -> ev_valid stays 0 and ev_count stays 0.
- btn_lvl 0 -> 4'b0100 at edge N, with ev_ready = 0:
  - ev_valid = 1 with ev_idx = 2 after edge N+1, ev_count = 1.
  - Assert ev_ready for one cycle -> ev_valid = 0 and ev_count = 0 on the next edge.
- btn_lvl 0 -> 4'b1011 in one cycle, with ev_ready = 1 continuously -> events ev_idx = 0, 1, 3 on three consecutive cycles; overflow stays 0.
- ev_ready = 0, then four presses on buttons 0, 1, 2, 3 (each released between presses):
  - Result: ev_count = 4.
  - A fifth press on button 0 leaves pend[0] = 1 and overflow = 0.
  - A sixth press on button 0 (after release) sets overflow = 1.
  - Then ev_ready = 1 drains idx 0, 1, 2, 3, 0 in order.
- With FIFO full and pend != 0, assert ev_ready for one cycle -> a simultaneous push and pop occurs; ev_count stays 4 and the new tail holds the granted index.
- overflow = 1, then pulse clr_ovf -> overflow = 0 on the next edge.
  - Same-cycle lost press with clr_ovf -> overflow = 1.
  - Assert rst with 3 queued entries -> ev_count = 0 and ev_valid = 0 on the next edge.
